// File: rtl/sbox_arbiter.sv
// sbox_arbiter: sequences the one-shot sbox table load, then arbitrates ke/sb word lookups onto the single LUT port.
// Latency: a granted word's substituted result is registered and returned one cycle after the grant; 1 word/cycle total.
// Backpressure: requesters hold req/val until gnt; no grants outside READY or in a reload cycle.
// Optional feature macro SBOX_ARB_RR_EN: round-robin arbitration (undefined: fixed priority, key-expansion wins).
module sbox_arbiter #(
    parameter int WORD_W       = 32,
    parameter int LOAD_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    output logic              sbox_load_vld,
    input  logic              sbox_available,
    output logic              load_err,
    output logic              ready,
    input  logic              ke_req,
    input  logic [WORD_W-1:0] ke_val,
    output logic              ke_gnt,
    output logic              ke_rsp_vld,
    output logic [WORD_W-1:0] ke_rsp_data,
    input  logic              sb_req,
    input  logic [WORD_W-1:0] sb_val,
    output logic              sb_gnt,
    output logic              sb_rsp_vld,
    output logic [WORD_W-1:0] sb_rsp_data,
    output logic [WORD_W-1:0] lut_val,
    output logic              lut_val_vld,
    input  logic [WORD_W-1:0] lut_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READY} state_t;

    // Last LOAD cycle index; without an acknowledge there, the load times out.
    localparam logic [7:0] LOAD_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t     state;
    logic [7:0] load_cnt;
    logic       serve;

    // Lookups are only served with a valid table, and a reload request steals the cycle.
    assign serve = (state == ST_READY) && !cfg_start;

`ifdef SBOX_ARB_RR_EN
    // Set when sub-bytes should win the next contention (i.e. key-expansion was granted last).
    logic rr_sb;

    // Round-robin: on contention the requester not granted most recently wins.
    always_comb begin
        ke_gnt = serve && ke_req && (!sb_req || !rr_sb);
        sb_gnt = serve && sb_req && (!ke_req || rr_sb);
    end

    // Pointer moves away from whichever requester was just granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_sb <= 1'b0;
        end else if (ke_gnt) begin
            rr_sb <= 1'b1;
        end else if (sb_gnt) begin
            rr_sb <= 1'b0;
        end
    end
`else
    // Fixed priority: key-expansion always wins contention.
    always_comb begin
        ke_gnt = serve && ke_req;
        sb_gnt = serve && sb_req && !ke_req;
    end
`endif

    // Present the winner's word to the LUT; the port is idle-zero when nobody is granted.
    always_comb begin
        lut_val_vld = ke_gnt || sb_gnt;
        lut_val     = '0;
        if (ke_gnt) begin
            lut_val = ke_val;
        end else if (sb_gnt) begin
            lut_val = sb_val;
        end
    end

    // Load/ready sequencing with registered strobe, error pulse and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            load_cnt      <= 8'd0;
            sbox_load_vld <= 1'b0;
            load_err      <= 1'b0;
            ready         <= 1'b0;
        end else begin
            sbox_load_vld <= 1'b0;
            load_err      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state         <= ST_LOAD;
                        load_cnt      <= 8'd0;
                        sbox_load_vld <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // An acknowledge in the final LOAD cycle still beats the timeout.
                    if (sbox_available) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end else if (load_cnt == LOAD_LAST) begin
                        state    <= ST_IDLE;
                        load_err <= 1'b1;
                    end else begin
                        load_cnt <= load_cnt + 8'd1;
                    end
                end
                ST_READY: begin
                    if (cfg_start) begin
                        state         <= ST_LOAD;
                        ready         <= 1'b0;
                        load_cnt      <= 8'd0;
                        sbox_load_vld <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Register the LUT result to the winner; the loser keeps its last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ke_rsp_vld  <= 1'b0;
            ke_rsp_data <= '0;
            sb_rsp_vld  <= 1'b0;
            sb_rsp_data <= '0;
        end else begin
            ke_rsp_vld <= ke_gnt;
            sb_rsp_vld <= sb_gnt;
            if (ke_gnt) begin
                ke_rsp_data <= lut_data;
            end
            if (sb_gnt) begin
                sb_rsp_data <= lut_data;
            end
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb_sbox_arbiter: drives the sbox_arbiter with a behavioural AES sbox LUT.
// Expected responses are queued at grant time and matched when rsp_vld pulses.
`timescale 1ns/1ps
module tb_sbox_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_start, sbox_load_vld, sbox_available, load_err, ready;
    logic         ke_req, ke_gnt, ke_rsp_vld, sb_req, sb_gnt, sb_rsp_vld;
    logic [W-1:0] ke_val, ke_rsp_data, sb_val, sb_rsp_data;
    logic [W-1:0] lut_val, lut_data;
    logic         lut_val_vld;
    logic [3*W+6:0] all_out;

    always #5 clk = ~clk;

    sbox_arbiter #(.WORD_W(W), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .sbox_load_vld(sbox_load_vld),
        .sbox_available(sbox_available), .load_err(load_err), .ready(ready),
        .ke_req(ke_req), .ke_val(ke_val), .ke_gnt(ke_gnt), .ke_rsp_vld(ke_rsp_vld), .ke_rsp_data(ke_rsp_data),
        .sb_req(sb_req), .sb_val(sb_val), .sb_gnt(sb_gnt), .sb_rsp_vld(sb_rsp_vld), .sb_rsp_data(sb_rsp_data),
        .lut_val(lut_val), .lut_val_vld(lut_val_vld), .lut_data(lut_data)
    );

    assign all_out = {sbox_load_vld, load_err, ready, ke_gnt, ke_rsp_vld, ke_rsp_data,
                      sb_gnt, sb_rsp_vld, sb_rsp_data, lut_val, lut_val_vld};

    // AES forward sbox, one 16-byte row per entry, byte 0 in the top bits.
    logic [127:0] srow [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < W / 8; i++) begin
            b = w[8*i +: 8];
            r[8*i +: 8] = srow[b[7:4]][8*(15 - int'(b[3:0])) +: 8];
        end
        return r;
    endfunction

    assign lut_data = sub_word(lut_val);

    typedef struct packed {
        logic         is_sb;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [W-1:0] mon_data;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    task automatic tick;
        @(negedge clk);
    endtask

    // Record the response the bench's own arbitration decision implies.
    task automatic note_grant(input logic is_sb, input logic [W-1:0] val);
        exp_q.push_back('{is_sb: is_sb, data: sub_word(val)});
    endtask

    // Scoreboard consumer: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en && (ke_rsp_vld || sb_rsp_vld)) begin
            total += 1;
            if (exp_q.size() == 0) begin
                bad += 1;
                $display("FAIL rsp_unexpected: ke_rsp_vld=%0b sb_rsp_vld=%0b, none expected", ke_rsp_vld, sb_rsp_vld);
            end else begin
                mon_e = exp_q.pop_front();
                mon_data = sb_rsp_vld ? sb_rsp_data : ke_rsp_data;
                if ({ke_rsp_vld, sb_rsp_vld} !== {!mon_e.is_sb, mon_e.is_sb} || mon_data !== mon_e.data) begin
                    bad += 1;
                    $display("FAIL rsp_scoreboard: got ke=%0b sb=%0b data=%h, want sb=%0b data=%h",
                             ke_rsp_vld, sb_rsp_vld, mon_data, mon_e.is_sb, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset;
        ke_req = 1'b1; sb_req = 1'b1; ke_val = 32'hdeadbeef; sb_val = 32'h01234567;
        #12;
        total += 1;
        if (all_out !== '0) begin bad += 1; $display("FAIL reset_outputs: got %h want 0", all_out); end
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick; #1;
            total += 1;
            if ({ready, ke_gnt, sb_gnt, lut_val_vld} !== 4'b0) begin
                bad += 1; $display("FAIL idle_no_grant: got %b want 0000", {ready, ke_gnt, sb_gnt, lut_val_vld});
            end
        end
        ke_req = 1'b0; sb_req = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_load;
        tick; cfg_start = 1'b1; ke_req = 1'b1; ke_val = 32'h11223344; #1;
        total += 1;
        if ({sbox_load_vld, ke_gnt} !== 2'b00) begin bad += 1; $display("FAIL load_idle: got %b want 00", {sbox_load_vld, ke_gnt}); end
        tick; cfg_start = 1'b0;
        total += 1;
        if ({sbox_load_vld, ready} !== 2'b10) begin bad += 1; $display("FAIL load_strobe: got %b want 10", {sbox_load_vld, ready}); end
        #1; total += 1;
        if ({ke_gnt, sb_gnt} !== 2'b00) begin bad += 1; $display("FAIL load_no_gnt: got %b want 00", {ke_gnt, sb_gnt}); end
        tick;
        total += 1;
        if ({sbox_load_vld, ready} !== 2'b00) begin bad += 1; $display("FAIL load_strobe_once: got %b want 00", {sbox_load_vld, ready}); end
        sbox_available = 1'b1;
        tick; sbox_available = 1'b0;
        total += 1;
        if ({ready, load_err} !== 2'b10) begin bad += 1; $display("FAIL ready_after_ack: got %b want 10", {ready, load_err}); end
        #1; total += 1;
        if ({ke_gnt, lut_val_vld, lut_val} !== {2'b11, 32'h11223344}) begin
            bad += 1; $display("FAIL held_req_granted: got gnt=%b vld=%b val=%h want 1 1 11223344", ke_gnt, lut_val_vld, lut_val);
        end
        note_grant(1'b0, 32'h11223344);
        tick; ke_req = 1'b0;
        tick;
        total += 1;
        if (exp_q.size() != 0) begin bad += 1; $display("FAIL load_rsp_drained: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_single;
        tick; ke_req = 1'b1; ke_val = 32'h00010203; #1;
        total += 1;
        if ({ke_gnt, sb_gnt, lut_val_vld, lut_val} !== {3'b101, 32'h00010203}) begin
            bad += 1; $display("FAIL single_gnt: got %b %b %b %h want 1 0 1 00010203", ke_gnt, sb_gnt, lut_val_vld, lut_val);
        end
        note_grant(1'b0, 32'h00010203);
        tick; ke_req = 1'b0; ke_val = '0;
        total += 1;
        if ({ke_rsp_vld, ke_rsp_data, sb_rsp_data} !== {1'b1, 32'h637c777b, 32'h0}) begin
            bad += 1; $display("FAIL single_rsp: got %b %h %h want 1 637c777b 00000000", ke_rsp_vld, ke_rsp_data, sb_rsp_data);
        end
        #1; total += 1;
        if ({lut_val_vld, lut_val} !== 33'h0) begin bad += 1; $display("FAIL lut_idle: got %b %h want 0 0", lut_val_vld, lut_val); end
        tick;
        total += 1;
        if ({ke_rsp_vld, ke_rsp_data} !== {1'b0, 32'h637c777b}) begin
            bad += 1; $display("FAIL rsp_pulse_hold: got %b %h want 0 637c777b", ke_rsp_vld, ke_rsp_data);
        end
    endtask

    task automatic test_lone_sb;
        tick; sb_req = 1'b1; sb_val = 32'hc0ffee00; #1;
        total += 1;
        if ({ke_gnt, sb_gnt, lut_val} !== {2'b01, 32'hc0ffee00}) begin
            bad += 1; $display("FAIL lone_sb_gnt: got %b %b %h want 0 1 c0ffee00", ke_gnt, sb_gnt, lut_val);
        end
        note_grant(1'b1, 32'hc0ffee00);
        tick; sb_req = 1'b0;
        total += 1;
        if ({sb_rsp_vld, ke_rsp_data} !== {1'b1, 32'h637c777b}) begin
            bad += 1; $display("FAIL loser_hold: got %b %h want 1 637c777b", sb_rsp_vld, ke_rsp_data);
        end
    endtask

    // The lone sub-bytes grant just before leaves key-expansion favoured for round-robin.
    task automatic test_contention;
        logic [W-1:0] kv, sv;
        logic [1:0]   exp;
        kv = $urandom; sv = $urandom;
        for (int i = 0; i < 4; i++) begin
            tick; ke_req = 1'b1; sb_req = 1'b1; ke_val = kv; sb_val = sv; #1;
`ifdef SBOX_ARB_RR_EN
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            total += 1;
            if ({sb_gnt, ke_gnt} !== exp || lut_val !== (exp[1] ? sv : kv)) begin
                bad += 1; $display("FAIL contention_%0d: got sb/ke=%b%b val=%h want %b val=%h", i, sb_gnt, ke_gnt, lut_val, exp, exp[1] ? sv : kv);
            end
            note_grant(exp[1], exp[1] ? sv : kv);
            if (exp[1]) sv = $urandom; else kv = $urandom;
        end
        tick; ke_req = 1'b0; sb_req = 1'b0;
        tick;
        total += 1;
        if (exp_q.size() != 0) begin bad += 1; $display("FAIL contention_drained: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reload;
        logic [W-1:0] sv;
        sv = $urandom;
        tick; sb_req = 1'b1; sb_val = sv; #1;
        total += 1;
        if (sb_gnt !== 1'b1) begin bad += 1; $display("FAIL reload_pre_gnt: got %b want 1", sb_gnt); end
        note_grant(1'b1, sv);
        sv = $urandom;
        tick; sb_val = sv; cfg_start = 1'b1;
        total += 1;
        if (sb_rsp_vld !== 1'b1) begin bad += 1; $display("FAIL reload_pending_rsp: got %b want 1", sb_rsp_vld); end
        #1; total += 1;
        if ({ke_gnt, sb_gnt, lut_val_vld} !== 3'b000) begin bad += 1; $display("FAIL reload_no_gnt: got %b want 000", {ke_gnt, sb_gnt, lut_val_vld}); end
        tick; cfg_start = 1'b0;
        total += 1;
        if ({sbox_load_vld, ready, sb_rsp_vld} !== 3'b100) begin
            bad += 1; $display("FAIL reload_strobe: got %b want 100", {sbox_load_vld, ready, sb_rsp_vld});
        end
        tick; sbox_available = 1'b1; #1;
        total += 1;
        if ({ready, sb_gnt} !== 2'b00) begin bad += 1; $display("FAIL reload_hold: got %b want 00", {ready, sb_gnt}); end
        tick; sbox_available = 1'b0; #1;
        total += 1;
        if ({ready, sb_gnt, lut_val} !== {2'b11, sv}) begin
            bad += 1; $display("FAIL reload_resume: got %b %b %h want 1 1 %h", ready, sb_gnt, lut_val, sv);
        end
        note_grant(1'b1, sv);
        tick; sb_req = 1'b0;
        tick;
        total += 1;
        if (exp_q.size() != 0) begin bad += 1; $display("FAIL reload_drained: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_ack_at_timeout;
        bit early;
        early = 1'b0;
        tick; cfg_start = 1'b1;
        tick; cfg_start = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick;
            if (load_err || ready) early = 1'b1;
        end
        sbox_available = 1'b1;
        tick; sbox_available = 1'b0;
        total += 1;
        if ({early, ready, load_err} !== 3'b010) begin
            bad += 1; $display("FAIL ack_wins_timeout: got early=%b ready=%b err=%b want 0 1 0", early, ready, load_err);
        end
    endtask

    task automatic test_timeout;
        int errs, err_at;
        bit stray;
        errs = 0; err_at = -1; stray = 1'b0;
        tick; cfg_start = 1'b1;
        tick; cfg_start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (load_err) begin errs++; if (err_at < 0) err_at = i; end
            if (ready || sbox_load_vld) stray = 1'b1;
        end
        total += 1;
        if (errs != 1 || err_at != TO) begin bad += 1; $display("FAIL timeout_err: got %0d pulses at %0d want 1 at %0d", errs, err_at, TO); end
        total += 1;
        if (stray) begin bad += 1; $display("FAIL timeout_ready: got ready/strobe after load want none"); end
        ke_req = 1'b1; ke_val = 32'h12345678;
        tick; #1;
        total += 1;
        if ({ready, ke_gnt} !== 2'b00) begin bad += 1; $display("FAIL timeout_idle: got %b want 00", {ready, ke_gnt}); end
        ke_req = 1'b0;
    endtask

    task automatic test_async_reset;
        tick; cfg_start = 1'b1;
        tick; cfg_start = 1'b0; sbox_available = 1'b1;
        tick; sbox_available = 1'b0;
        total += 1;
        if (ready !== 1'b1) begin bad += 1; $display("FAIL areset_ready: got %b want 1", ready); end
        mon_en = 1'b0;
        ke_req = 1'b1; ke_val = 32'haabbccdd;
        tick; ke_val = 32'h55667788;
        total += 1;
        if (ke_rsp_vld !== 1'b1) begin bad += 1; $display("FAIL areset_first_rsp: got %b want 1", ke_rsp_vld); end
        #1; total += 1;
        if (ke_gnt !== 1'b1) begin bad += 1; $display("FAIL areset_inflight_gnt: got %b want 1", ke_gnt); end
        #2; reset = 1'b1; #1;
        total += 1;
        if (all_out !== '0) begin bad += 1; $display("FAIL areset_outputs: got %h want 0", all_out); end
        tick; tick; reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick; #1;
            total += 1;
            if ({ke_rsp_vld, sb_rsp_vld, ke_gnt, ready} !== 4'b0) begin
                bad += 1; $display("FAIL areset_after_%0d: got %b want 0000", i, {ke_rsp_vld, sb_rsp_vld, ke_gnt, ready});
            end
        end
        ke_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_start = 1'b0; sbox_available = 1'b0;
        ke_req = 1'b0; ke_val = '0; sb_req = 1'b0; sb_val = '0;
        test_reset;
        test_load;
        test_single;
        test_lone_sb;
        test_contention;
        test_reload;
        test_ack_at_timeout;
        test_timeout;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
